bist_tpg: RTL and testbench
===========================

// Module: bist_tpg
// PURPOSE
//   LFSR-based test-pattern generator and BIST sequencer: stimulus end of the BIST loop whose response end is the MISR.
//   Drives NUM_PAT pseudo-random vectors into the CUT, clears/enables the MISR, waits out pipeline latency, then reports done.
//   Sits between the BIST controller (start/done) and the CUT input pins.
// PARAMETERS
//   WIDTH    15       LFSR length in bits
//   TAPS     15'h6000 feedback mask (x^15+x^14+1, maximal, period 32767)
//   SEED     15'h0001 LFSR load value; 0 is illegal and is replaced by 1
//   OUT_W    3        pattern width driven to CUT (lfsr[OUT_W-1:0]), OUT_W<=WIDTH
//   NUM_PAT  100      patterns per session, 1..2^16-1
//   FLUSH    2        cycles after last pattern before MISR signature is final
//   GOLDEN   15'h0000 expected signature (used only with BIST_SIG_CHECK_EN)
// PORTS
//   CLK        in   1      clock, all logic on posedge
//   RST        in   1      synchronous reset, active-high
//   start      in   1      level request to run a session
//   pat        out  OUT_W  CUT stimulus (e0..e2 of the CUT for OUT_W=3)
//   pat_valid  out  1      pat is a counted test vector this cycle
//   misr_clr   out  1      one-cycle MISR clear pulse
//   misr_en    out  1      MISR capture enable
//   busy       out  1      session in progress (LOAD/RUN/FLUSH)
//   done       out  1      session finished, held until start low
//   sig        in   WIDTH  MISR signature (only with BIST_SIG_CHECK_EN)
//   pass       out  1      signature==GOLDEN (only with BIST_SIG_CHECK_EN)
// BEHAVIOUR
//   - Reset: state=IDLE, lfsr=SEED(nonzero), cnt=0; pat=0, pat_valid=0, misr_clr=0, misr_en=0, busy=0, done=0, pass=0.
//   - LFSR: fb = ^(lfsr & TAPS); next = {lfsr[WIDTH-2:0], fb}; advances only in RUN. pat = lfsr[OUT_W-1:0], 0 outside RUN.
//   - FSM (all outputs registered):
//     IDLE : start=1 -> LOAD.
//     LOAD : 1 cycle; lfsr<=SEED, cnt<=0, misr_clr=1, busy=1 -> RUN.
//     RUN  : pat_valid=1, misr_en=1; cnt++ each cycle; exactly NUM_PAT cycles, first vector = SEED[OUT_W-1:0]; cnt==NUM_PAT-1 -> FLUSH.
//     FLUSH: pat_valid=0, misr_en=1 for FLUSH cycles (FLUSH=0 skips straight to DONE) -> DONE.
//     DONE : busy=0, done=1, misr_en=0; start=0 -> IDLE (done drops next cycle).
//   - Latency: start high at cycle 0 -> misr_clr at 1, first pat_valid at 2, done at 2+NUM_PAT+FLUSH.
//   - start ignored while busy; start held high through DONE does not retrigger (needs a 0 first).
//   - RST mid-session: abort on that edge, all outputs to reset values, no done pulse.
//   - Lockup: if lfsr ever reads 0 it is reloaded with 1 next cycle.
//   - cnt is 16 bits, no wrap within a legal session.
// CONFIGURATION
//   `BIST_SIG_CHECK_EN defined: sig/pass ports exist; in the cycle of entry to DONE pass <= (sig==GOLDEN), held through DONE, cleared on IDLE/RST.
//   Undefined: sig and pass ports absent; pass/fail decided externally from the MISR output.
// STRUCTURE
//   - Package bist_pkg: state enum {IDLE,LOAD,RUN,FLUSH,DONE} (3 bits), default TAPS/SEED constants, WIDTH=15.
//   - Sub-module lfsr_core (WIDTH,TAPS,SEED; ports CLK,RST,load,adv,q) holds the shift register and lockup guard.
//   - bist_tpg holds FSM, pattern counter, flush counter, output registers.
// TESTING
//   1. RST=1 two cycles with start=1 -> all outputs 0, state IDLE, no misr_clr.
//   2. Defaults, start pulse held -> misr_clr at cycle 1; pat = 1,2,4,0,0,... per lfsr 0001,0002,0004,0008; exactly 100 pat_valid cycles; done at cycle 104.
//   3. NUM_PAT=1, FLUSH=0 -> one pat_valid (pat=1), done at cycle 3; start low -> done low next cycle, IDLE.
//   4. RST asserted mid-RUN (cycle 50) -> outputs zero next edge, no done; new start runs a full 100-vector session from SEED.
//   5. SEED=0, WIDTH=4, TAPS=4'hC, NUM_PAT=15 -> lfsr starts at 1, visits all 15 nonzero states, never 0.
//   6. With BIST_SIG_CHECK_EN, sig=GOLDEN at DONE entry -> pass=1; sig=GOLDEN^1 -> pass=0; pass clears in IDLE.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and default LFSR constants for the BIST pattern generator.
package bist_pkg;
  localparam int WIDTH = 15;
  localparam logic [WIDTH-1:0] DEF_TAPS = 15'h6000;
  localparam logic [WIDTH-1:0] DEF_SEED = 15'h0001;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/bist_tpg_if.sv
// bist_tpg_if: controller/CUT-side bundle of bist_tpg; sig/pass exist only with `BIST_SIG_CHECK_EN.
interface bist_tpg_if #(
  parameter int OUT_W = 3
`ifdef BIST_SIG_CHECK_EN
  , parameter int WIDTH = 15
`endif
);
  logic start, pat_valid, misr_clr, misr_en, busy, done;
  logic [OUT_W-1:0] pat;
`ifdef BIST_SIG_CHECK_EN
  logic [WIDTH-1:0] sig;
  logic pass;
  modport master (input start, sig, output pat, pat_valid, misr_clr, misr_en, busy, done, pass);
  modport slave (output start, sig, input pat, pat_valid, misr_clr, misr_en, busy, done, pass);
`else
  modport master (input start, output pat, pat_valid, misr_clr, misr_en, busy, done);
  modport slave (output start, input pat, pat_valid, misr_clr, misr_en, busy, done);
`endif
endinterface

// File: rtl/bist_tpg_lfsr_core.sv
// lfsr_core: Fibonacci LFSR shifting left; an all-zero state is forced back to 1.
module lfsr_core #(
  parameter int WIDTH = 15,
  parameter logic [WIDTH-1:0] TAPS = 15'h6000,
  parameter logic [WIDTH-1:0] SEED = 15'h0001
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic adv,
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] INIT = SEED == '0 ? WIDTH'(1) : SEED;
  always_ff @(posedge CLK)
    if (RST || load) q <= INIT;
    else if (q == '0) q <= WIDTH'(1);
    else if (adv) q <= {q[WIDTH-2:0], ^(q & TAPS)};
endmodule

// File: rtl/bist_tpg.sv
// bist_tpg: LFSR test-pattern generator and BIST session sequencer (IDLE/LOAD/RUN/FLUSH/DONE).
// `BIST_SIG_CHECK_EN adds the sig input and the registered pass verdict.
module bist_tpg #(
  parameter int WIDTH = bist_pkg::WIDTH,
  parameter logic [WIDTH-1:0] TAPS = bist_pkg::DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED = bist_pkg::DEF_SEED,
  parameter int OUT_W = 3,
  parameter int NUM_PAT = 100,
  parameter int FLUSH = 2
`ifdef BIST_SIG_CHECK_EN
  , parameter logic [WIDTH-1:0] GOLDEN = '0
`endif
) (
  input logic CLK,
  input logic RST,
  bist_tpg_if.master bus
);
  import bist_pkg::*;
  state_t state, nxt;
  logic [15:0] cnt, fcnt;
  logic [WIDTH-1:0] q;
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .CLK, .RST, .load(state == LOAD), .adv(state == RUN), .q
  );
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      fcnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state == RUN ? cnt + 16'd1 : '0;
      fcnt <= state == bist_pkg::FLUSH ? fcnt + 16'd1 : '0;
    end
  // FLUSH the parameter is the drain length; bist_pkg::FLUSH is the state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:            nxt = bus.start ? LOAD : IDLE;
      LOAD:            nxt = RUN;
      RUN:             nxt = cnt == 16'(NUM_PAT - 1) ? (FLUSH == 0 ? DONE : bist_pkg::FLUSH) : RUN;
      bist_pkg::FLUSH: nxt = fcnt == 16'(FLUSH - 1) ? DONE : bist_pkg::FLUSH;
      DONE:            nxt = bus.start ? DONE : IDLE;
      default:         nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.pat = state == RUN ? q[OUT_W-1:0] : '0;
    bus.pat_valid = state == RUN;
    bus.misr_clr = state == LOAD;
    bus.misr_en = state == RUN || state == bist_pkg::FLUSH;
    bus.busy = state == LOAD || state == RUN || state == bist_pkg::FLUSH;
    bus.done = state == DONE;
  end
`ifdef BIST_SIG_CHECK_EN
  // verdict latched on DONE entry, held through DONE, dropped with it
  always_ff @(posedge CLK)
    if (RST) bus.pass <= 1'b0;
    else bus.pass <= nxt == DONE && (state == DONE ? bus.pass : bus.sig == GOLDEN);
`endif
endmodule

// File: tb/tb_bist_tpg.sv
// tb_bist_tpg: scoreboard bench for bist_tpg; three instances (default, 1-pattern no-flush, 4-bit zero-seed).
module tb_bist_tpg;
  import bist_pkg::*;
  logic CLK, RST;
  logic [2:0] st, dn, bz;
  int n_chk, n_fail, cyc;
  int clr_at[3], first_at[3], done_at[3], npv[3];
  logic [31:0] q[3][$];
  logic [15:0] seen;
`ifdef BIST_SIG_CHECK_EN
  logic [14:0] sg1;
  bist_tpg_if #(.OUT_W(3), .WIDTH(15)) b0 ();
  bist_tpg_if #(.OUT_W(3), .WIDTH(15)) b1 ();
  bist_tpg_if #(.OUT_W(3), .WIDTH(4)) b2 ();
  assign b0.sig = '0;
  assign b1.sig = sg1;
  assign b2.sig = '0;
`else
  bist_tpg_if #(.OUT_W(3)) b0 ();
  bist_tpg_if #(.OUT_W(3)) b1 ();
  bist_tpg_if #(.OUT_W(3)) b2 ();
`endif
  assign b0.start = st[0];
  assign b1.start = st[1];
  assign b2.start = st[2];
  assign dn = {b2.done, b1.done, b0.done};
  assign bz = {b2.busy, b1.busy, b0.busy};
  bist_tpg u0 (.CLK(CLK), .RST(RST), .bus(b0));
  bist_tpg #(.NUM_PAT(1), .FLUSH(0)) u1 (.CLK(CLK), .RST(RST), .bus(b1));
  bist_tpg #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h0), .NUM_PAT(15)) u2 (.CLK(CLK), .RST(RST), .bus(b2));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic push(input int i, input int w, input logic [31:0] taps, input logic [31:0] seed, input int n);
    logic [31:0] v;
    v = seed == 0 ? 32'd1 : seed;
    for (int k = 0; k < n; k++) begin
      q[i].push_back(v);
      v = ((v << 1) | 32'(^(v & taps))) & ((32'd1 << w) - 1);
    end
  endtask
  task automatic cycle();
    logic [2:0] v, c;
    logic [2:0] p[3];
    logic [31:0] e;
    @(negedge CLK);
    cyc++;
    v = {b2.pat_valid, b1.pat_valid, b0.pat_valid};
    c = {b2.misr_clr, b1.misr_clr, b0.misr_clr};
    p[0] = b0.pat;
    p[1] = b1.pat;
    p[2] = b2.pat;
    for (int i = 0; i < 3; i++) begin
      if (c[i]) clr_at[i] = cyc;
      if (dn[i] && done_at[i] == 0) done_at[i] = cyc;
      if (!v[i]) chk($sformatf("pat_idle%0d", i), 32'(p[i]), 32'd0);
      else begin
        npv[i]++;
        if (first_at[i] == 0) first_at[i] = cyc;
        if (q[i].size() == 0) chk($sformatf("pat_extra%0d", i), 32'd1, 32'd0);
        else begin
          e = q[i].pop_front();
          chk($sformatf("pat%0d", i), 32'(p[i]), e & 32'd7);
          if (i == 2) begin
            chk("lfsr2", 32'(u2.u_lfsr.q), e);
            seen[u2.u_lfsr.q] = 1'b1;
          end
        end
      end
    end
  endtask
  task automatic session(input int i, input int w, input logic [31:0] taps, input logic [31:0] seed, input int n, input int lat);
    int t0, n0;
    push(i, w, taps, seed, n);
    n0 = npv[i];
    clr_at[i] = 0;
    first_at[i] = 0;
    done_at[i] = 0;
    st[i] = 1'b1;
    t0 = cyc;
    for (int k = 0; k < lat + 20 && done_at[i] == 0; k++) cycle();
    chk($sformatf("clr_at%0d", i), clr_at[i] - t0, 32'd1);
    chk($sformatf("first_pv%0d", i), first_at[i] - t0, 32'd2);
    chk($sformatf("done_at%0d", i), done_at[i] - t0, lat);
    chk($sformatf("npv%0d", i), npv[i] - n0, n);
    chk($sformatf("q_empty%0d", i), q[i].size(), 32'd0);
`ifdef BIST_SIG_CHECK_EN
    if (i == 1) chk("pass1", 32'(b1.pass), 32'(sg1 == 15'h0));
`endif
    repeat (3) cycle();
    chk($sformatf("done_held%0d", i), 32'(dn[i]), 32'd1);
    chk($sformatf("busy_done%0d", i), 32'(bz[i]), 32'd0);
    chk($sformatf("no_retrig%0d", i), clr_at[i] - t0, 32'd1);
    st[i] = 1'b0;
    cycle();
    chk($sformatf("done_drop%0d", i), 32'(dn[i]), 32'd0);
`ifdef BIST_SIG_CHECK_EN
    if (i == 1) chk("pass_clr", 32'(b1.pass), 32'd0);
`endif
  endtask
  initial begin
    int t0;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    seen = '0;
    RST = 1'b1;
    st = '1;
`ifdef BIST_SIG_CHECK_EN
    sg1 = '0;
`endif
    cycle();
    cycle();
    chk("rst_state", 32'(u0.state), 32'(IDLE));
    chk("rst_busy", 32'(b0.busy), 32'd0);
    chk("rst_clr", 32'(b0.misr_clr), 32'd0);
    chk("rst_en", 32'(b0.misr_en), 32'd0);
    chk("rst_done", 32'(b0.done), 32'd0);
    chk("rst_lfsr", 32'(u0.u_lfsr.q), 32'd1);
    RST = 1'b0;
    st = '0;
    cycle();
    session(0, 15, 32'h6000, 32'h1, 100, 104);
    session(1, 15, 32'h6000, 32'h1, 1, 3);
`ifdef BIST_SIG_CHECK_EN
    sg1 = 15'h1;
    session(1, 15, 32'h6000, 32'h1, 1, 3);
`endif
    session(2, 4, 32'hC, 32'h0, 15, 19);
    chk("seen2", 32'(seen), 32'hFFFE);
    done_at[0] = 0;
    push(0, 15, 32'h6000, 32'h1, 100);
    st[0] = 1'b1;
    t0 = cyc;
    while (cyc - t0 < 50) cycle();
    RST = 1'b1;
    st[0] = 1'b0;
    cycle();
    chk("abort_busy", 32'(b0.busy), 32'd0);
    chk("abort_pv", 32'(b0.pat_valid), 32'd0);
    chk("abort_en", 32'(b0.misr_en), 32'd0);
    chk("abort_state", 32'(u0.state), 32'(IDLE));
    q[0].delete();
    RST = 1'b0;
    repeat (5) cycle();
    chk("abort_nodone", done_at[0], 32'd0);
    session(0, 15, 32'h6000, 32'h1, 100, 104);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
